writeback_arbiter: RTL and testbench



---
 rtl/writeback_pkg.sv | 15 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/writeback_arbiter.sv | 128 ++++++++++++
 tb/tb_writeback_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Purpose : shared defaults and the result-entry type for the writeback path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package writeback_pkg;

    localparam int WB_ADDRESS_WIDTH = 5;
    localparam int WB_DATA_WIDTH    = 32;

    // One queued long-latency result: destination register and its value.
    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose : synchronous FIFO of result entries (entry type is a parameter).
// Latency : a push becomes visible at the head one edge later; pop is same-edge.
// Backpressure: full blocks pushes, empty blocks pops (both ignored, not errors).
//
// Ports: clk/rst (async, active-high); push/push_dat write side;
//        pop/head read side (head valid when !empty); full/empty status.
module sync_fifo
    import writeback_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_dat,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    // Pointers alone alias full and empty; the count tells them apart.
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Purpose : sole driver of the register-file write port; merges primary and
//           queued long-latency results and keeps the operand busy scoreboard.
// Latency : primary 1 cycle; secondary >= 2 cycles (FIFO then output register).
// Backpressure: primary never stalls; secondary sees SREADY_o=0 when FIFO full.
//
// Ports: PWE_i/PAD_i/PWD_i primary write; ISSUE_i/ISSUE_AD_i long-latency issue;
//        SVALID_i/SAD_i/SWD_i/SREADY_o secondary result handshake;
//        AD1_i/AD2_i/STALL_o decode operand check; AD3_o/WE3_o/WD3_o write port.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PWE_i,
    input  logic [ADDRESS_WIDTH-1:0] PAD_i,
    input  logic [DATA_WIDTH-1:0]    PWD_i,
    input  logic                     ISSUE_i,
    input  logic [ADDRESS_WIDTH-1:0] ISSUE_AD_i,
    input  logic                     SVALID_i,
    input  logic [ADDRESS_WIDTH-1:0] SAD_i,
    input  logic [DATA_WIDTH-1:0]    SWD_i,
    output logic                     SREADY_o,
    input  logic [ADDRESS_WIDTH-1:0] AD1_i,
    input  logic [ADDRESS_WIDTH-1:0] AD2_i,
    output logic                     STALL_o,
    output logic [ADDRESS_WIDTH-1:0] AD3_o,
    output logic                     WE3_o,
    output logic [DATA_WIDTH-1:0]    WD3_o
);

    localparam int NREG = 2 ** ADDRESS_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    entry_t          push_dat;
    entry_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            prim_active;
    logic            pop;
    logic            sec_q;      // the write now on the port came from the FIFO
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            clear_now;

    // Writes to x0 are no-ops, so they leave the port free for the FIFO.
    assign prim_active = PWE_i & (PAD_i != '0);
    assign pop         = ~prim_active & ~fifo_empty;
    assign SREADY_o    = ~fifo_full;
    assign push_dat    = '{addr: SAD_i, data: SWD_i};

    sync_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (SVALID_i),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Output register. A popped x0 entry is consumed but never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3_o <= 1'b0;
            AD3_o <= '0;
            WD3_o <= '0;
            sec_q <= 1'b0;
        end else if (prim_active) begin
            WE3_o <= 1'b1;
            AD3_o <= PAD_i;
            WD3_o <= PWD_i;
            sec_q <= 1'b0;
        end else if (pop) begin
            WE3_o <= (head.addr != '0);
            AD3_o <= head.addr;
            WD3_o <= head.data;
            sec_q <= 1'b1;
        end else begin
            WE3_o <= 1'b0;
            sec_q <= 1'b0;
        end
    end

    // The busy bit drops on the same edge the register file commits, so the
    // first cycle without a stall already reads the new value.
    assign clear_now = WE3_o & sec_q;

    always_comb begin
        busy_next = busy;
        if (clear_now) begin
            busy_next[AD3_o] = 1'b0;
        end
        // Applied after the clear so a same-edge re-issue keeps the bit set.
        if (ISSUE_i) begin
            busy_next[ISSUE_AD_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign STALL_o = ((AD1_i != '0) & busy[AD1_i]) | ((AD2_i != '0) & busy[AD2_i]);

    // Re-issuing to a destination whose result is still outstanding is illegal,
    // except on the very edge that result commits.
    a_no_double_issue : assert property (@(posedge clk) disable iff (rst)
        !(ISSUE_i && (ISSUE_AD_i != '0) && busy[ISSUE_AD_i]
          && !(clear_now && (AD3_o == ISSUE_AD_i))));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Purpose : directed self-checking bench for writeback_arbiter.
// Latency : inputs driven 1 time unit after each rising edge, outputs checked there.
// Backpressure: exercises FIFO full (SREADY_o low) under a continuous primary stream.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        PWE_i;
    logic [4:0]  PAD_i;
    logic [31:0] PWD_i;
    logic        ISSUE_i;
    logic [4:0]  ISSUE_AD_i;
    logic        SVALID_i;
    logic [4:0]  SAD_i;
    logic [31:0] SWD_i;
    logic        SREADY_o;
    logic [4:0]  AD1_i;
    logic [4:0]  AD2_i;
    logic        STALL_o;
    logic [4:0]  AD3_o;
    logic        WE3_o;
    logic [31:0] WD3_o;

    int checks;
    int errors;

    writeback_arbiter #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PWE_i      (PWE_i),
        .PAD_i      (PAD_i),
        .PWD_i      (PWD_i),
        .ISSUE_i    (ISSUE_i),
        .ISSUE_AD_i (ISSUE_AD_i),
        .SVALID_i   (SVALID_i),
        .SAD_i      (SAD_i),
        .SWD_i      (SWD_i),
        .SREADY_o   (SREADY_o),
        .AD1_i      (AD1_i),
        .AD2_i      (AD2_i),
        .STALL_o    (STALL_o),
        .AD3_o      (AD3_o),
        .WE3_o      (WE3_o),
        .WD3_o      (WD3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic port_chk(input string tag, input logic we, input logic [4:0] ad,
                            input logic [31:0] wd);
        chk({tag, ".we"}, 64'(WE3_o), 64'(we));
        if (we) begin
            chk({tag, ".ad"}, 64'(AD3_o), 64'(ad));
            chk({tag, ".wd"}, 64'(WD3_o), 64'(wd));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        PWE_i = 1'b0; PAD_i = '0; PWD_i = '0;
        ISSUE_i = 1'b0; ISSUE_AD_i = '0;
        SVALID_i = 1'b0; SAD_i = '0; SWD_i = '0;
        AD1_i = '0; AD2_i = '0;
        step();
        step();
        chk("rst.we", 64'(WE3_o), 64'(0));
        chk("rst.ad", 64'(AD3_o), 64'(0));
        chk("rst.wd", 64'(WD3_o), 64'(0));
        chk("rst.stall", 64'(STALL_o), 64'(0));
        chk("rst.srdy", 64'(SREADY_o), 64'(1));
        rst = 1'b0;

        // Primary write, latency 1, then idle.
        PWE_i = 1'b1; PAD_i = 5'd3; PWD_i = 32'hDEADBEEF;
        step();
        PWE_i = 1'b0;
        port_chk("prim", 1'b1, 5'd3, 32'hDEADBEEF);
        step();
        port_chk("prim.idle", 1'b0, '0, '0);

        // Issue to x7, stall, secondary result commits two cycles after accept.
        ISSUE_i = 1'b1; ISSUE_AD_i = 5'd7;
        step();
        ISSUE_i = 1'b0;
        AD1_i = 5'd7;
        #1;
        chk("sb.stall_set", 64'(STALL_o), 64'(1));
        SVALID_i = 1'b1; SAD_i = 5'd7; SWD_i = 32'd42;
        #1;
        chk("sec.srdy", 64'(SREADY_o), 64'(1));
        step();
        SVALID_i = 1'b0;
        port_chk("sec.n1", 1'b0, '0, '0);
        step();
        port_chk("sec.n2", 1'b1, 5'd7, 32'd42);
        chk("sb.stall_hold", 64'(STALL_o), 64'(1));
        step();
        chk("sb.stall_clr", 64'(STALL_o), 64'(0));
        port_chk("sec.after", 1'b0, '0, '0);
        AD1_i = '0;

        // Continuous primary stream fills the FIFO; secondaries wait.
        for (int i = 0; i < 5; i++) begin
            PWE_i = 1'b1; PAD_i = 5'(10 + i); PWD_i = 32'(100 + i);
            SVALID_i = 1'b1; SAD_i = 5'(20 + i); SWD_i = 32'(200 + i);
            #1;
            chk($sformatf("full.srdy%0d", i), 64'(SREADY_o), 64'(i < 4 ? 1 : 0));
            step();
            port_chk($sformatf("full.prim%0d", i), 1'b1, 5'(10 + i), 32'(100 + i));
        end
        PWE_i = 1'b0; SVALID_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            port_chk($sformatf("drain%0d", i), 1'b1, 5'(20 + i), 32'(200 + i));
        end
        step();
        port_chk("drain.done", 1'b0, '0, '0);
        chk("drain.srdy", 64'(SREADY_o), 64'(1));

        // x0 secondary is discarded; x0 primary counts as idle and lets the FIFO drain.
        SVALID_i = 1'b1; SAD_i = 5'd0; SWD_i = 32'd5;
        step();
        SAD_i = 5'd12; SWD_i = 32'd77;
        PWE_i = 1'b1; PAD_i = 5'd0; PWD_i = 32'h11111111;
        step();
        port_chk("x0.sec", 1'b0, '0, '0);
        SVALID_i = 1'b0;
        PWD_i = 32'h22222222;
        step();
        port_chk("x0.prim_drain", 1'b1, 5'd12, 32'd77);
        PWE_i = 1'b0;
        step();
        port_chk("x0.idle", 1'b0, '0, '0);

        // Same-edge clear of x9 and re-issue to x9: the bit stays set.
        ISSUE_i = 1'b1; ISSUE_AD_i = 5'd9;
        step();
        ISSUE_i = 1'b0;
        SVALID_i = 1'b1; SAD_i = 5'd9; SWD_i = 32'd99;
        step();
        SVALID_i = 1'b0;
        step();
        port_chk("setclr.port", 1'b1, 5'd9, 32'd99);
        ISSUE_i = 1'b1; ISSUE_AD_i = 5'd9;
        step();
        ISSUE_i = 1'b0;
        AD2_i = 5'd9;
        #1;
        chk("setclr.stall", 64'(STALL_o), 64'(1));

        // Mid-operation reset with 3 queued entries and 2 busy bits.
        ISSUE_i = 1'b1; ISSUE_AD_i = 5'd15;
        PWE_i = 1'b1; PAD_i = 5'd1; PWD_i = 32'd1;
        SVALID_i = 1'b1; SAD_i = 5'd9; SWD_i = 32'd900;
        step();
        ISSUE_i = 1'b0;
        SAD_i = 5'd15; SWD_i = 32'd1500;
        step();
        SAD_i = 5'd16; SWD_i = 32'd1600;
        step();
        PWE_i = 1'b0; SVALID_i = 1'b0;
        AD1_i = 5'd15; AD2_i = 5'd9;
        #1;
        chk("prerst.stall", 64'(STALL_o), 64'(1));
        port_chk("prerst.port", 1'b1, 5'd1, 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst.we", 64'(WE3_o), 64'(0));
        chk("mrst.ad", 64'(AD3_o), 64'(0));
        chk("mrst.wd", 64'(WD3_o), 64'(0));
        chk("mrst.srdy", 64'(SREADY_o), 64'(1));
        chk("mrst.stall", 64'(STALL_o), 64'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("postrst.we%0d", i), 64'(WE3_o), 64'(0));
        end
        chk("postrst.stall", 64'(STALL_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
